// File: rtl/fft_output_reorder.sv
// fft_output_reorder: converts a bit-reversed-order FFT output stream into natural bin order.
//   clk        rising-edge master clock
//   rst        asynchronous, active-high reset
//   di_en      input valid, high for N consecutive cycles per frame
//   di_re/im   input sample; input position k carries bin bitrev(k)
//   do_en      output valid
//   do_re/im   output sample in natural bin order (held while do_en=0)
//   do_idx     bin index of the current output sample
//   do_last    high with bin N-1 of each output frame
//   err_abort  one-cycle pulse after a partial input frame is dropped
module fft_output_reorder #(
    parameter int N = 128,
    parameter int WIDTH = 16,
    localparam int LOG_N = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic [LOG_N-1:0] do_idx,
    output logic             do_last,
    output logic             err_abort
);
    localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

    typedef enum logic {IDLE, READ} state_t;

    state_t             state_q, state_d;
    logic [LOG_N-1:0]   wr_cnt_q, wr_cnt_d;
    logic [LOG_N-1:0]   rd_cnt_q, rd_cnt_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [1:0]         full_q, full_d;
    logic               err_q, err_d;
    logic               rd_fire;
    logic               do_en_q, do_last_q;
    logic [WIDTH-1:0]   do_re_q, do_im_q;
    logic [LOG_N-1:0]   do_idx_q;
    logic [2*WIDTH-1:0] mem [2][N];
    logic [2*WIDTH-1:0] rd_word;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] k);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) r[i] = k[LOG_N-1-i];
        return r;
    endfunction

    assign rd_word = mem[rd_bank_q][rd_cnt_q];

    // Scatter writes so the readout can walk addresses linearly.
    always_ff @(posedge clk) begin
        if (di_en) mem[wr_bank_q][bitrev(wr_cnt_q)] <= {di_re, di_im};
    end

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        err_d     = 1'b0;
        rd_fire   = 1'b0;
        if (state_q == READ) begin
            rd_fire  = 1'b1;
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                state_d           = full_q[~rd_bank_q] ? READ : IDLE;
            end
        end else if (full_q[rd_bank_q]) begin
            state_d  = READ;
            rd_cnt_d = '0;
        end
        // Applied after the read-side clear so a completing write wins.
        if (di_en) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end else if (wr_cnt_q != '0) begin
            wr_cnt_d = '0;
            err_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            err_q     <= 1'b0;
            do_en_q   <= 1'b0;
            do_last_q <= 1'b0;
            do_idx_q  <= '0;
            do_re_q   <= '0;
            do_im_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            err_q     <= err_d;
            do_en_q   <= rd_fire;
            do_last_q <= rd_fire && rd_cnt_q == LAST;
            if (rd_fire) begin
                do_idx_q <= rd_cnt_q;
                do_re_q  <= rd_word[2*WIDTH-1:WIDTH];
                do_im_q  <= rd_word[WIDTH-1:0];
            end
        end
    end

    assign do_en     = do_en_q;
    assign do_last   = do_last_q;
    assign do_idx    = do_idx_q;
    assign do_re     = do_re_q;
    assign do_im     = do_im_q;
    assign err_abort = err_q;
endmodule

// File: tb/tb_fft_output_reorder.sv
// tb_fft_output_reorder: directed and random frames checked against a natural-order reference model.
module tb_fft_output_reorder;
    localparam int N = 128;
    localparam int W = 16;
    localparam int L = 7;

    typedef struct packed {
        logic [31:0]  c;
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [L-1:0] idx;
        logic         last;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         di_en = 1'b0;
    logic [W-1:0] di_re = '0;
    logic [W-1:0] di_im = '0;
    logic         do_en, do_last, err_abort;
    logic [W-1:0] do_re, do_im;
    logic [L-1:0] do_idx;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ovf = 0;
    int   last_p;
    int   ab;
    rec_t got[$];
    rec_t exp_q[$];
    int   errs[$];
    logic [W-1:0] fr_re[N];
    logic [W-1:0] fr_im[N];

    fft_output_reorder #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .di_en(di_en), .di_re(di_re), .di_im(di_im),
        .do_en(do_en), .do_re(do_re), .do_im(do_im), .do_idx(do_idx),
        .do_last(do_last), .err_abort(err_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (do_en) got.push_back({32'(cyc), do_re, do_im, do_idx, do_last});
        if (err_abort) errs.push_back(cyc);
        if (di_en && dut.wr_cnt_q == L'(N - 1) && dut.full_q[dut.wr_bank_q]) ovf++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int brev(input int v);
        int r = 0;
        int k = v;
        for (int i = 0; i < L; i++) begin
            r = r * 2 + k % 2;
            k = k / 2;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [71:0] o, input logic [71:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            di_en = 1'b0;
        end
    endtask

    task automatic fill(input int off, input bit rnd);
        for (int k = 0; k < N; k++) begin
            fr_re[k] = rnd ? W'($urandom) : W'(brev(k) + off);
            fr_im[k] = rnd ? W'($urandom) : W'(~(brev(k) + off));
        end
    endtask

    // Output bin b is the sample that arrived at input position bitrev(b),
    // appearing 3 counted cycles after the last input was driven.
    task automatic send_frame();
        for (int k = 0; k < N; k++) begin
            @(posedge clk);
            #1;
            di_en = 1'b1;
            di_re = fr_re[k];
            di_im = fr_im[k];
        end
        last_p = cyc;
        for (int b = 0; b < N; b++)
            exp_q.push_back({32'(last_p + 3 + b), fr_re[brev(b)], fr_im[brev(b)], L'(b), b == N - 1});
    endtask

    task automatic drain_check(input string tag, input int n_err);
        int n;
        idle(140);
        check({tag, "_count"}, 72'(got.size()), 72'(exp_q.size()));
        n = got.size() < exp_q.size() ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
        check({tag, "_errs"}, 72'(errs.size()), 72'(n_err));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", 72'(do_en), 72'(0));
        check("rst_last", 72'(do_last), 72'(0));
        check("rst_err", 72'(err_abort), 72'(0));
        check("rst_idx", 72'(do_idx), 72'(0));
        check("rst_re", 72'(do_re), 72'(0));
        check("rst_im", 72'(do_im), 72'(0));
        rst = 1'b0;
        idle(3);

        fill(0, 0);
        send_frame();
        drain_check("single", 0);

        fill(0, 0);
        send_frame();
        fill(1000, 0);
        send_frame();
        drain_check("b2b", 0);

        fill(0, 0);
        send_frame();
        idle(5);
        fill(500, 0);
        send_frame();
        drain_check("gap5", 0);

        fill(0, 1);
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            di_en = 1'b1;
            di_re = fr_re[k];
            di_im = fr_im[k];
        end
        @(posedge clk);
        #1;
        di_en = 1'b0;
        ab = cyc;
        idle(3);
        fill(2000, 0);
        send_frame();
        drain_check("abort", 1);
        check("abort_when", 72'(errs.size() > 0 ? errs[0] : -1), 72'(ab + 1));
        errs.delete();

        fill(3000, 0);
        send_frame();
        for (int i = 0; i < 60 && cyc < last_p + 43; i++) begin
            @(posedge clk);
            #1;
            di_en = 1'b0;
        end
        check("pre_rst_idx", 72'(do_idx), 72'(40));
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_en", 72'(do_en), 72'(0));
        check("mid_rst_idx", 72'(do_idx), 72'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        exp_q.delete();
        errs.delete();
        idle(2);
        fill(0, 1);
        send_frame();
        drain_check("post_rst", 0);

        for (int f = 0; f < 20; f++) begin
            fill(0, 1);
            send_frame();
        end
        drain_check("stress", 0);
        check("overflow", 72'(ovf), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_output_reorder.md
Name: fft_output_reorder

Overview:
- Sits directly downstream of the last SDF butterfly stage of the 128-point FFT pipeline.
- Consumes the stage's bit-reversed-order output stream (do_en/do_re/do_im) and re-emits each frame in natural bin order.
- Uses a ping-pong double buffer, so continuous back-to-back frames stream through with no gaps.

Parameters:
- N, 128, FFT size in points; power of two, at least 4. LOG_N = log2(N).
- WIDTH, 16, bit width of each real and imaginary sample.

Ports:
- clk  input  1  master clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- di_en  input  1  input sample valid; high for N consecutive cycles per frame.
- di_re  input  WIDTH  input sample, real part; input position k holds bin bitrev(k).
- di_im  input  WIDTH  input sample, imaginary part.
- do_en  output  1  output sample valid.
- do_re  output  WIDTH  output sample, real part, natural bin order.
- do_im  output  WIDTH  output sample, imaginary part.
- do_idx  output  LOG_N  bin index of the current output sample.
- do_last  output  1  high with the final sample (bin N-1) of each output frame.
- err_abort  output  1  one-cycle pulse when an input frame is aborted.

Behaviour:
- Reset: do_en, do_last, err_abort, do_idx, do_re, do_im, both bank-full flags, the write counter, the read counter and the bank pointers all go to 0.
  - RAM contents are not cleared.
  - A reset mid-frame or mid-readout discards all in-flight data; the first output after reset comes from the next complete input frame.
- Storage: two banks of N x 2*WIDTH RAM. Writes are synchronous. Reads are registered, giving 1 cycle of read latency.
- Bit reversal: bitrev(k) reverses all LOG_N bits of k. For N=128, bitrev(1)=64 and bitrev(3)=96.
- Write side:
  - wr_cnt counts from 0 to N-1 on each cycle with di_en=1.
  - The sample is written to bank wr_bank at address bitrev(wr_cnt).
  - On the write with wr_cnt=N-1: set full[wr_bank], toggle wr_bank, wrap wr_cnt to 0.
- Abort: di_en=0 while 0 < wr_cnt < N.
  - wr_cnt returns to 0 and full[wr_bank] stays 0, so the partial frame is dropped.
  - err_abort pulses high the following cycle.
  - di_en=0 when wr_cnt=0 is idle, not an abort.
- Read FSM, states IDLE and READ:
  - IDLE -> READ when full[rd_bank]=1. rd_cnt=0 at entry.
  - In READ, the block issues address rd_cnt on bank rd_bank and increments rd_cnt.
  - After address N-1 is issued: clear full[rd_bank] and toggle rd_bank.
  - Then go to READ again if the other bank is already full (no bubble), otherwise go to IDLE.
- Output timing:
  - Data for address a appears on do_re/do_im one cycle after the address is issued, with do_en=1, do_idx=a and do_last=(a==N-1).
  - do_en is 0 otherwise. do_re/do_im hold their last value when do_en=0.
- Latency: the frame's last input is sampled at edge T; do_en is first high after edge T+2. Each output frame is exactly N contiguous cycles.
- Simultaneous events:
  - Clearing full[x] and setting full[y] on the same edge are independent, because x != y by construction.
  - If a write completes into the bank being cleared on that same edge, the set wins.
- Overflow: with a non-stalling reader it cannot occur at any legal input rate, so there is no overflow handling. The bench asserts that the write never completes into a bank whose full flag is still set.
- Widths: no arithmetic on data; samples pass through bit-exact.

Test Plan:
- Single frame, N=128, di_re=bitrev(k) and di_im=~bitrev(k) at position k -> after edge T+2, 128 contiguous do_en cycles with do_re=do_idx=0..127, do_im=~do_idx, do_last only at idx 127.
- Two frames back to back (256 contiguous di_en), second frame offset by +1000 -> 256 contiguous do_en cycles with no gap; second frame do_re=1000..1127.
- Frames separated by a 5-cycle di_en gap -> two 128-cycle output bursts separated by exactly 5 idle cycles.
- Abort: drop di_en after 50 samples, then send a full frame -> err_abort is a single one-cycle pulse; only one 128-sample output frame appears, and it matches the full frame.
- Reset at output idx 40 during readout, then one frame -> do_en=0 immediately after reset; the next output frame is exactly the post-reset frame, in correct order.
- Random-data stress: 20 random back-to-back frames -> the scoreboard matches natural-order bins exactly, and the overflow assertion never fires.
